// File: rtl/vend_fsm_param.sv
// Parametrised coin-accumulating vending controller: per-product price table,
// change return, cancel/refund and a timed dispense pulse. All outputs registered.
module vend_fsm_param #(
    parameter int unsigned NUM_PRODUCTS    = 4,
    parameter int unsigned COIN_W          = 4,
    parameter int unsigned SUM_W           = 8,
    parameter logic [NUM_PRODUCTS*SUM_W-1:0] PRICES = {8'd10, 8'd5, 8'd1, 8'd2},
    parameter int unsigned DISPENSE_CYCLES = 4,
    localparam int unsigned SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_value,
    input  logic              sel_valid,
    input  logic [SEL_W-1:0]  sel,
    input  logic              cancel,
    input  logic              change_ready,
    output logic              dispense,
    output logic              change_valid,
    output logic [SUM_W-1:0]  change_amount,
    output logic              coin_reject,
    output logic [SUM_W-1:0]  credit,
    output logic              led_green,
    output logic              led_yellow
);

    localparam int unsigned ACC_W = SUM_W + 1;
    localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   credit_q, credit_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_vld_q, sel_vld_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dispense_q, dispense_d;
    logic               change_valid_q, change_valid_d;
    logic [SUM_W-1:0]   change_amount_q, change_amount_d;
    logic               coin_reject_q, coin_reject_d;
    logic               led_green_q, led_green_d;
    logic               led_yellow_q, led_yellow_d;

    logic [SUM_W-1:0]   price_tbl [NUM_PRODUCTS];
    logic [SUM_W-1:0]   price_c;
    logic [ACC_W-1:0]   sum_c;
    logic               sel_ok_c;
    logic               purchase_c;

    // Unpack the flat price table into one entry per product.
    for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_price
        assign price_tbl[i] = PRICES[i*SUM_W +: SUM_W];
    end

    assign price_c    = price_tbl[sel_q];
    assign sum_c      = ACC_W'(credit_q) + ACC_W'(coin_value);
    assign sel_ok_c   = (32'(sel) < NUM_PRODUCTS);
    assign purchase_c = sel_vld_q && (credit_q >= price_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            sel_q           <= '0;
            sel_vld_q       <= 1'b0;
            cnt_q           <= '0;
            dispense_q      <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
            coin_reject_q   <= 1'b0;
            led_green_q     <= 1'b1;
            led_yellow_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            sel_q           <= sel_d;
            sel_vld_q       <= sel_vld_d;
            cnt_q           <= cnt_d;
            dispense_q      <= dispense_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
            coin_reject_q   <= coin_reject_d;
            led_green_q     <= led_green_d;
            led_yellow_q    <= led_yellow_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        sel_d           = sel_q;
        sel_vld_d       = sel_vld_q;
        cnt_d           = cnt_q;
        change_valid_d  = change_valid_q;
        change_amount_d = change_amount_q;
        coin_reject_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    state_d = S_COLLECT;
                    if (sum_c[SUM_W]) coin_reject_d = 1'b1;
                    else              credit_d      = sum_c[SUM_W-1:0];
                end
                if (sel_valid && sel_ok_c) begin
                    state_d   = S_COLLECT;
                    sel_d     = sel;
                    sel_vld_d = 1'b1;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    change_amount_d = credit_q;
                    credit_d        = '0;
                    sel_d           = '0;
                    sel_vld_d       = 1'b0;
                    coin_reject_d   = coin_valid;
                    if (credit_q != '0) begin
                        state_d        = S_CHANGE;
                        change_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (purchase_c) begin
                    // The credit is consumed now, so a coin arriving this cycle goes back.
                    change_amount_d = credit_q - price_c;
                    credit_d        = '0;
                    sel_d           = '0;
                    sel_vld_d       = 1'b0;
                    cnt_d           = CNT_W'(DISPENSE_CYCLES - 1);
                    coin_reject_d   = coin_valid;
                    state_d         = S_DISPENSE;
                end else begin
                    if (coin_valid) begin
                        if (sum_c[SUM_W]) coin_reject_d = 1'b1;
                        else              credit_d      = sum_c[SUM_W-1:0];
                    end
                    if (sel_valid && sel_ok_c) begin
                        sel_d     = sel;
                        sel_vld_d = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (cnt_q == '0) begin
                    if (change_amount_q != '0) begin
                        state_d        = S_CHANGE;
                        change_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    change_valid_d  = 1'b0;
                    change_amount_d = '0;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        dispense_d   = (state_d == S_DISPENSE);
        led_yellow_d = (state_d == S_DISPENSE);
        led_green_d  = (state_d == S_IDLE);
    end

    assign dispense      = dispense_q;
    assign change_valid  = change_valid_q;
    assign change_amount = change_amount_q;
    assign coin_reject   = coin_reject_q;
    assign credit        = credit_q;
    assign led_green     = led_green_q;
    assign led_yellow    = led_yellow_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_vend_fsm_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       change_ready;
    logic       dispense;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       coin_reject;
    logic [7:0] credit;
    logic       led_green;
    logic       led_yellow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vend_fsm_param dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .change_ready (change_ready),
        .dispense     (dispense),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .led_green    (led_green),
        .led_yellow   (led_yellow)
    );

    // {inputs, expected outputs after the next rising edge}
    typedef struct packed {
        logic       cv;
        logic [3:0] cval;
        logic       sv;
        logic [1:0] s;
        logic       cn;
        logic       rdy;
        logic       d;
        logic       chv;
        logic [7:0] amt;
        logic       rej;
        logic [7:0] cr;
        logic       g;
        logic       y;
    } vec_t;

    vec_t vecs [20];

    // Product i takes bits [i*8 +: 8] of {10,5,1,2}.
    int price_of [4] = '{2, 1, 5, 10};

    // Reference model: open session, credit, pending pick, dispense time left, refund owed.
    int m_credit, m_pick, m_disp, m_amt;
    bit m_open, m_pay, m_rej;

    function automatic logic [20:0] pk(logic d, logic chv, logic [7:0] amt, logic rej,
                                       logic [7:0] cr, logic g, logic y);
        return {d, chv, amt, rej, cr, g, y};
    endfunction

    function automatic logic [20:0] outs();
        return pk(dispense, change_valid, change_amount, coin_reject, credit, led_green, led_yellow);
    endfunction

    function automatic logic [20:0] model_outs();
        return pk(m_disp > 0, m_pay, 8'(m_amt), m_rej, 8'(m_credit),
                  !m_open && m_disp == 0 && !m_pay, m_disp > 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic cv, input logic [3:0] cval, input logic sv,
                       input logic [1:0] s, input logic cn, input logic rdy);
        coin_valid   = cv;
        coin_value   = cval;
        sel_valid    = sv;
        sel          = s;
        cancel       = cn;
        change_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_credit = 0; m_pick = -1; m_disp = 0; m_amt = 0;
        m_open = 0; m_pay = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit cv, input int cval, input bit sv, input int s,
                              input bit cn, input bit rdy);
        m_rej = 0;
        if (m_disp > 0) begin
            m_rej = cv;
            m_disp--;
            if (m_disp == 0 && m_amt != 0) m_pay = 1;
        end else if (m_pay) begin
            m_rej = cv;
            if (rdy) begin m_pay = 0; m_amt = 0; end
        end else if (!m_open) begin
            if (cv) begin m_credit += cval; m_open = 1; end
            if (sv && s < 4) begin m_pick = s; m_open = 1; end
        end else if (cn) begin
            m_rej = cv; m_amt = m_credit; m_credit = 0; m_pick = -1; m_open = 0;
            m_pay = (m_amt != 0);
        end else if (m_pick >= 0 && m_credit >= price_of[m_pick]) begin
            m_rej = cv; m_amt = m_credit - price_of[m_pick]; m_credit = 0;
            m_pick = -1; m_open = 0; m_disp = 4;
        end else begin
            if (cv) begin
                if (m_credit + cval > 255) m_rej = 1;
                else m_credit += cval;
            end
            if (sv && s < 4) m_pick = s;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       r_cv, r_sv, r_cn, r_rdy;
        logic [3:0] r_cval;
        logic [1:0] r_s;

        //             cv cval sv s  cn rdy  d chv amt rej cr g y
        vecs[0]  = '{0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[4]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{1, 5, 0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 1};
        vecs[10] = '{0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 1};
        vecs[11] = '{1, 2, 0, 0, 0, 0,  1, 0, 3, 1, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0, 1};
        vecs[13] = '{0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0};
        vecs[15] = '{1, 1, 0, 0, 0, 0,  0, 1, 3, 1, 0, 0, 0};
        vecs[16] = '{0, 0, 1, 2, 1, 0,  0, 1, 3, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0};
        vecs[18] = '{0, 0, 0, 0, 0, 0,  0, 1, 3, 0, 0, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0};

        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));
        rst = 1'b1;

        // Exact price and overpay transactions, cycle by cycle.
        for (int i = 0; i < 20; i++) begin
            drv(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].s, vecs[i].cn, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'(pk(vecs[i].d, vecs[i].chv, vecs[i].amt, vecs[i].rej,
                         vecs[i].cr, vecs[i].g, vecs[i].y)));
        end

        // Multi-coin with reselection: last selection (price 10) wins.
        drv(1, 2, 0, 0, 0, 0); tick();
        drv(1, 2, 0, 0, 0, 0); tick();
        check("mc_credit4", 32'(credit), 32'd4);
        drv(0, 0, 1, 2, 0, 0); tick();
        drv(0, 0, 1, 3, 0, 0); tick();
        check("mc_no_buy_at_4", 32'(dispense), 32'd0);
        drv(1, 4, 0, 0, 0, 0); tick();
        drv(1, 2, 0, 0, 0, 0); tick();
        check("mc_credit10_latency", 32'(outs()), 32'(pk(0, 0, 0, 0, 10, 0, 0)));
        drv(0, 0, 0, 0, 0, 0); tick();
        check("mc_dispense_p10", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0, 1)));
        repeat (4) tick();
        check("mc_idle_no_change", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));
        drv(0, 0, 1, 2, 0, 0); tick();
        drv(1, 4, 0, 0, 0, 0); tick();
        drv(1, 2, 0, 0, 0, 0); tick();
        check("mc_credit6", 32'(credit), 32'd6);
        drv(0, 0, 0, 0, 0, 0); tick();
        check("mc_dispense_p5", 32'(outs()), 32'(pk(1, 0, 1, 0, 0, 0, 1)));
        repeat (4) tick();
        check("mc_change1", 32'(outs()), 32'(pk(0, 1, 1, 0, 0, 0, 0)));
        drv(0, 0, 0, 0, 0, 1); tick();
        check("mc_change_done", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));

        // Cancel beats a coin in the same cycle.
        drv(1, 3, 0, 0, 0, 0); tick();
        drv(1, 4, 0, 0, 0, 0); tick();
        check("cn_credit7", 32'(credit), 32'd7);
        drv(1, 1, 0, 0, 1, 0); tick();
        check("cn_refund", 32'(outs()), 32'(pk(0, 1, 7, 1, 0, 0, 0)));
        drv(0, 0, 0, 0, 0, 1); tick();
        check("cn_done", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));

        // Accumulator overflow boundary.
        for (int i = 0; i < 16; i++) begin
            drv(1, 15, 0, 0, 0, 0); tick();
        end
        drv(1, 10, 0, 0, 0, 0); tick();
        check("ov_credit250", 32'(credit), 32'd250);
        drv(1, 8, 0, 0, 0, 0); tick();
        check("ov_reject", 32'(outs()), 32'(pk(0, 0, 0, 1, 250, 0, 0)));
        drv(1, 5, 0, 0, 0, 0); tick();
        check("ov_max255", 32'(outs()), 32'(pk(0, 0, 0, 0, 255, 0, 0)));
        drv(0, 0, 0, 0, 1, 0); tick();
        check("ov_refund255", 32'(outs()), 32'(pk(0, 1, 255, 0, 0, 0, 0)));
        drv(0, 0, 0, 0, 0, 1); tick();
        check("ov_done", 32'(led_green), 32'd1);

        // Asynchronous reset in the middle of a dispense with change pending.
        drv(0, 0, 1, 0, 0, 0); tick();
        drv(1, 5, 0, 0, 0, 0); tick();
        drv(0, 0, 0, 0, 0, 0); tick();
        tick();
        check("ar_mid_dispense", 32'(outs()), 32'(pk(1, 0, 3, 0, 0, 0, 1)));
        #2 rst = 1'b0;
        #1;
        check("ar_immediate", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));
        tick();
        rst = 1'b1;
        tick();
        check("ar_released_idle", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 1, 0)));

        // Randomized run against the reference model.
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            r_cv   = ($urandom_range(99) < 40);
            r_cval = 4'($urandom_range(15));
            r_sv   = ($urandom_range(99) < 10);
            r_s    = 2'($urandom_range(3));
            r_cn   = ($urandom_range(99) < 3);
            r_rdy  = ($urandom_range(99) < 50);
            drv(r_cv, r_cval, r_sv, r_s, r_cn, r_rdy);
            model_step(r_cv, int'(r_cval), r_sv, int'(r_s), r_cn, r_rdy);
            tick();
            check($sformatf("rand%0d", k), 32'(outs()), 32'(model_outs()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
